// File: rtl/byte_packer.sv
// byte_packer: reassembles pairs of 8-bit bytes into 16-bit words; optional parity via BYTE_PACKER_PARITY_EN.
// Latency: word valid one cycle after the edge accepting its second byte (or the flush).
// Backpressure: din_ready drops only while a word is held and dout_ready is low; held words stay stable.
module byte_packer #(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  datain,
    input  logic        din_valid,
    output logic        din_ready,
`ifdef BYTE_PACKER_PARITY_EN
    input  logic        din_par,
    output logic        dout_perr,
`endif
    input  logic        flush,
    output logic [15:0] dataout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_partial,
    output logic [15:0] word_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_hold;
    logic [15:0] r_dataout;
    logic        r_partial;
    logic [15:0] r_word_count;

    logic        w_byte_xfer;
    logic        w_word_xfer;
    logic [15:0] w_pair_word;
    logic [15:0] w_pad_word;
    logic        w_in_bad;

    // A held word can be replaced in the same cycle it leaves, so ready looks through to dout_ready.
    assign din_ready    = (r_state != ST_FULL) | dout_ready;
    assign dout_valid   = (r_state == ST_FULL);
    assign dataout      = r_dataout;
    assign dout_partial = r_partial;
    assign word_count   = r_word_count;

    assign w_byte_xfer  = din_valid & din_ready;
    assign w_word_xfer  = dout_valid & dout_ready;

    // The held byte is always the first of the pair; the pad fills the second slot.
    assign w_pair_word  = MSB_FIRST ? {r_hold, datain} : {datain, r_hold};
    assign w_pad_word   = MSB_FIRST ? {r_hold, PAD_BYTE} : {PAD_BYTE, r_hold};

`ifdef BYTE_PACKER_PARITY_EN
    logic r_hold_bad;
    logic r_perr;

    // Even parity: a good byte has an even number of ones across data and parity bit.
    assign w_in_bad  = ^{datain, din_par};
    assign dout_perr = r_perr;

    // Track the parity error of the held byte and fold it into the word when it completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_bad <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            if (w_byte_xfer && (r_state != ST_HALF)) begin
                r_hold_bad <= w_in_bad;
            end
            if (r_state == ST_HALF) begin
                if (w_byte_xfer) begin
                    r_perr <= r_hold_bad | w_in_bad;
                end else if (flush) begin
                    r_perr <= r_hold_bad;
                end
            end
        end
    end
`else
    assign w_in_bad = 1'b0;
`endif

    // Pairing state machine plus the sink-side word counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_EMPTY;
            r_hold       <= 8'h00;
            r_dataout    <= 16'h0000;
            r_partial    <= 1'b0;
            r_word_count <= 16'h0000;
        end else begin
            if (w_word_xfer) begin
                r_word_count <= r_word_count + 16'd1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_byte_xfer) begin
                        r_hold  <= datain;
                        r_state <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    // A byte arriving with flush completes the word normally; the flush is dropped.
                    if (w_byte_xfer) begin
                        r_dataout <= w_pair_word;
                        r_partial <= 1'b0;
                        r_state   <= ST_FULL;
                    end else if (flush) begin
                        r_dataout <= w_pad_word;
                        r_partial <= 1'b1;
                        r_state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_word_xfer) begin
                        if (w_byte_xfer) begin
                            r_hold  <= datain;
                            r_state <= ST_HALF;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Referenced so the default build carries no dangling signal.
    logic w_unused;
    assign w_unused = w_in_bad;

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: directed scenarios followed by random traffic against a pairing model.
// Two instances (MSB-first and LSB-first) share stimulus; the expected word queue drives both checks.
// Parity ports are exercised when BYTE_PACKER_PARITY_EN is defined.
module tb_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  datain;
    logic        din_valid;
    logic        din_ready, din_ready_l;
    logic        flush;
    logic [15:0] dataout, dataout_l;
    logic        dout_valid, dout_valid_l;
    logic        dout_ready;
    logic        dout_partial, dout_partial_l;
    logic [15:0] word_count, word_count_l;
    logic        par_in;
`ifdef BYTE_PACKER_PARITY_EN
    logic        dout_perr, dout_perr_l;
`endif

    always #5 clk = ~clk;

    byte_packer #(.MSB_FIRST(1'b1), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst(rst), .datain(datain), .din_valid(din_valid), .din_ready(din_ready),
`ifdef BYTE_PACKER_PARITY_EN
        .din_par(par_in), .dout_perr(dout_perr),
`endif
        .flush(flush), .dataout(dataout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_partial(dout_partial), .word_count(word_count)
    );

    byte_packer #(.MSB_FIRST(1'b0), .PAD_BYTE(8'h00)) dut_lsb (
        .clk(clk), .rst(rst), .datain(datain), .din_valid(din_valid), .din_ready(din_ready_l),
`ifdef BYTE_PACKER_PARITY_EN
        .din_par(par_in), .dout_perr(dout_perr_l),
`endif
        .flush(flush), .dataout(dataout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
        .dout_partial(dout_partial_l), .word_count(word_count_l)
    );

    typedef struct packed {
        logic [15:0] w_m;
        logic [15:0] w_l;
        logic        part;
        logic        perr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  held;
    logic        held_vld = 1'b0;
    logic        held_bad = 1'b0;
    logic [15:0] cnt = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every word the sink takes must be the oldest expected word.
    always @(posedge clk) begin
        exp_t e;
        if (rst === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_word", {16'h0, dataout}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("word_msb", {16'h0, dataout}, {16'h0, e.w_m});
                chk("word_lsb", {16'h0, dataout_l}, {16'h0, e.w_l});
                chk("partial", {31'h0, dout_partial}, {31'h0, e.part});
                chk("lsb_valid", {31'h0, dout_valid_l}, 32'h1);
`ifdef BYTE_PACKER_PARITY_EN
                chk("perr", {31'h0, dout_perr}, {31'h0, e.perr});
`endif
            end
        end
    end

    // One clock of stimulus with cycle-level checks of the registered outputs and din_ready.
    task automatic cycle(input logic v, input logic [7:0] b, input logic f, input logic r, input logic p);
        logic exp_rdy, acc, bad;
        exp_t e;
        @(negedge clk);
        chk("dout_valid", {31'h0, dout_valid}, {31'h0, (q.size() != 0)});
        if (q.size() != 0) begin
            chk("hold_dataout", {16'h0, dataout}, {16'h0, q[0].w_m});
            chk("hold_partial", {31'h0, dout_partial}, {31'h0, q[0].part});
        end
        chk("word_count", {16'h0, word_count}, {16'h0, cnt});
        din_valid  = v;
        datain     = b;
        flush      = f;
        dout_ready = r;
        par_in     = p;
        #1;
        exp_rdy = (q.size() == 0) || r;
        chk("din_ready", {31'h0, din_ready}, {31'h0, exp_rdy});
        acc = v && exp_rdy;
`ifdef BYTE_PACKER_PARITY_EN
        bad = ^{b, p};
`else
        bad = 1'b0;
`endif
        if ((q.size() != 0) && r) cnt = cnt + 16'd1;
        @(posedge clk);
        if (acc) begin
            if (held_vld) begin
                e.w_m = {held, b}; e.w_l = {b, held}; e.part = 1'b0; e.perr = held_bad | bad;
                q.push_back(e);
                held_vld = 1'b0;
            end else begin
                held = b; held_vld = 1'b1; held_bad = bad;
            end
        end else if (f && held_vld) begin
            e.w_m = {held, 8'h00}; e.w_l = {8'h00, held}; e.part = 1'b1; e.perr = held_bad;
            q.push_back(e);
            held_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
        @(posedge clk);
        q.delete();
        held_vld = 1'b0;
        cnt = 16'h0000;
        @(negedge clk);
        chk("rst_dout_valid", {31'h0, dout_valid}, 32'h0);
        chk("rst_dataout", {16'h0, dataout}, 32'h0);
        chk("rst_partial", {31'h0, dout_partial}, 32'h0);
        chk("rst_word_count", {16'h0, word_count}, 32'h0);
        chk("rst_din_ready", {31'h0, din_ready}, 32'h1);
`ifdef BYTE_PACKER_PARITY_EN
        chk("rst_perr", {31'h0, dout_perr}, 32'h0);
`endif
        rst = 1'b1;
    endtask

    task automatic byte_in(input logic [7:0] b, input logic r);
        cycle(1'b1, b, 1'b0, r, ^b);
    endtask

    task automatic idle(input logic f, input logic r);
        cycle(1'b0, 8'h00, f, r, 1'b0);
    endtask

    initial begin
        logic v, f, r, p;
        logic [7:0] b;
        rst = 1'b1; datain = 8'h00; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0; par_in = 1'b0;
        do_reset();

        // Back-to-back pairs with the sink always ready.
        byte_in(8'h35, 1'b1); byte_in(8'h24, 1'b1);
        byte_in(8'h5E, 1'b1); byte_in(8'h81, 1'b1);
        idle(1'b0, 1'b1); idle(1'b0, 1'b1);

        // Parity error on the second byte, then a clean pair.
        cycle(1'b1, 8'h35, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h24, 1'b0, 1'b1, 1'b1);
        byte_in(8'h35, 1'b1); byte_in(8'h24, 1'b1);
        idle(1'b0, 1'b1);

        // Backpressure: word held, byte refused, then taken with a new byte in the same edge.
        byte_in(8'hD6, 1'b0); byte_in(8'h09, 1'b0);
        byte_in(8'h11, 1'b0); byte_in(8'h11, 1'b0);
        byte_in(8'h56, 1'b1); byte_in(8'h57, 1'b1);
        idle(1'b0, 1'b1); idle(1'b0, 1'b1);

        // Flush variants: padded, coincident with a byte, and while empty.
        byte_in(8'h7B, 1'b1); idle(1'b1, 1'b1); idle(1'b0, 1'b1);
        byte_in(8'h99, 1'b1); cycle(1'b1, 8'h0D, 1'b1, 1'b1, ^8'h0D); idle(1'b0, 1'b1);
        idle(1'b1, 1'b1); idle(1'b0, 1'b1);

        // Reset while HALF, then while FULL, then a fresh pair.
        byte_in(8'h99, 1'b1);
        do_reset();
        byte_in(8'h99, 1'b0); byte_in(8'h98, 1'b0); idle(1'b0, 1'b0);
        do_reset();
        byte_in(8'h12, 1'b1); byte_in(8'h34, 1'b1); idle(1'b0, 1'b1); idle(1'b0, 1'b1);

        // Word counter wrap from a preloaded value.
        @(negedge clk);
        din_valid = 1'b0; flush = 1'b0;
        force dut.r_word_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_word_count;
        cnt = 16'hFFFE;
        byte_in(8'hA1, 1'b1); byte_in(8'hA2, 1'b1);
        byte_in(8'hA3, 1'b1); byte_in(8'hA4, 1'b1);
        idle(1'b0, 1'b1); idle(1'b0, 1'b1);
        chk("count_wrapped", {16'h0, cnt}, 32'h0);

        // Random traffic with occasional parity faults.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 6) == 0);
            r = ($urandom_range(0, 9) < 7);
            b = 8'($urandom_range(0, 255));
            p = (^b) ^ ($urandom_range(0, 7) == 0);
            cycle(v, b, f, r, p);
        end

        // Drain any held byte and pending word.
        idle(1'b1, 1'b1); idle(1'b1, 1'b1); idle(1'b1, 1'b1); idle(1'b0, 1'b1);
        chk("drain_empty", q.size(), 32'h0);
        chk("drain_valid", {31'h0, dout_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
# byte_packer

Byte-to-word packer: the receive-side counterpart of the 16-to-8 data converter. Accepts a stream of 8-bit bytes under a valid/ready handshake and reassembles each pair into one 16-bit word on a valid/ready output, so a converter→packer chain returns the original words. Sits at the byte-link receive end, ahead of 16-bit datapath logic. Provides explicit flush of a dangling half-word and a running count of emitted words.

## Interface
Parameters:
- MSB_FIRST, 1 — 1: first byte of a pair lands in dataout[15:8]; 0: first byte lands in dataout[7:0].
- PAD_BYTE, 8'h00 — filler for the missing byte on flush.

Ports:
- clk  input  1  — the single clock; all logic on posedge.
- rst  input  1  — synchronous, active-low reset; sampled on posedge clk.
- datain  input  8  — byte data, qualified by din_valid.
- din_valid  input  1  — byte present.
- din_ready  output  1  — packer accepts byte this cycle.
- flush  input  1  — single-cycle request to emit a held half-word.
- dataout  output  16  — packed word, qualified by dout_valid.
- dout_valid  output  1  — word present.
- dout_ready  input  1  — sink takes word this cycle.
- dout_partial  output  1  — current word was flushed (one byte is PAD_BYTE).
- word_count  output  16  — number of words accepted by sink, wraps.

## Operation
- States: EMPTY (no byte held), HALF (first byte held in hold register), FULL (word in output register, dout_valid=1).
- Transfers: byte when din_valid & din_ready; word when dout_valid & dout_ready.
- din_ready = (state != FULL) | dout_ready (combinational from dout_ready; no other combinational in→out paths).
- EMPTY: byte → hold, go HALF. flush ignored.
- HALF: byte → dataout = {hold, datain} (MSB_FIRST=1) or {datain, hold} (0), dout_partial=0, go FULL. flush without byte → word uses PAD_BYTE in second slot, dout_partial=1, go FULL. flush together with byte: byte completes the word normally, flush dropped.
- FULL: hold dataout/dout_partial stable until word transfer. Word transfer without byte → EMPTY. Word transfer with byte → byte to hold, go HALF. flush ignored.
- word_count increments by 1 per word transfer, modulo 2^16 (0xFFFF → 0x0000).
- Reset (rst=0 at posedge), anywhere including HALF/FULL: state EMPTY, held byte and pending word discarded, not counted.

## Timing
- Reset values: din_ready=1 (state EMPTY), dout_valid=0, dataout=16'h0000, dout_partial=0, word_count=0 (and dout_perr=0 when configured).
- Latency: second byte accepted at edge N → dout_valid=1 with the word after edge N (1 cycle).
- Flush accepted at edge N in HALF → padded word valid after edge N.
- Throughput: one byte per cycle sustained with dout_ready held high; one word per two cycles.
- dout_valid, once high, never drops without a word transfer (except reset); dataout stable meanwhile.

## Configuration
- Macro BYTE_PACKER_PARITY_EN.
- Defined: extra input din_par (1 bit, even parity over {datain, din_par}) and output dout_perr (1 bit). dout_perr is registered with the word: 1 if either contributing byte failed parity; pad byte counts as good. Reset 0; stable while FULL.
- Undefined: din_par and dout_perr ports absent; no parity logic; all other behaviour identical.

## Test plan
- Reset then bytes 0x35, 0x24, 0x5E, 0x81 back-to-back, dout_ready=1, MSB_FIRST=1 → words 0x3524 then 0x5E81, each valid one cycle after its second byte; word_count=2.
- Same bytes with MSB_FIRST=0 → 0x2435, 0x815E.
- Backpressure: dout_ready=0 while word 0xD609 FULL → din_ready=0, dataout held 0xD609; raise dout_ready with din_valid byte 0x56 → word taken and 0x56 held (HALF) same edge.
- Flush: byte 0x7B then flush → 0x7B00 with dout_partial=1; flush coincident with byte 0x0D in HALF holding 0x99 → 0x990D, dout_partial=0; flush in EMPTY → no output.
- rst=0 asserted while HALF holding 0x99 and again while FULL → outputs return to reset values next edge; subsequent 0x12, 0x34 → 0x1234; preload 0xFFFF transfers → word_count wraps to 0x0000.
- With BYTE_PACKER_PARITY_EN: 0x35 par=0, 0x24 par=1 (bad) → 0x3524 with dout_perr=1; correct parity on both → dout_perr=0.
